// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter: picks a requester's byte,
// strobes it into the transmitter and waits for TE to cycle before the next grant.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int TO_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       din,
    output logic [NREQ-1:0]         ack,
    input  logic                    TE,
    output logic                    load,
    output logic [7:0]              dout,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    err,
    input  logic                    err_clr,
    output logic [15:0]             tx_count
);

    // state     | meaning
    // IDLE      | waiting for TE=1 and a request
    // LOAD      | load/ack strobe cycle for the registered winner
    // WAIT_LOW  | waiting for TE to fall, bounded by TO_CYCLES
    // WAIT_HIGH | transmitter accepted the byte, waiting for TE to rise
    localparam int OW = $clog2(NREQ);
    localparam int TW = $clog2(TO_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_LOW, WAIT_HIGH} state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] ptr;
    logic [OW-1:0] winner;
    logic [OW-1:0] idx;
    logic          found;
    logic [TW-1:0] to_cnt;
    logic          to_expire;

    // Search starts at ptr; the index wraps naturally because NREQ is a power of two.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + OW'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign to_expire = (state == WAIT_LOW) && TE && (to_cnt == TW'(TO_CYCLES - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (TE && found) state_nxt = LOAD;
            LOAD:      state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (!TE)            state_nxt = WAIT_HIGH;
                else if (to_expire) state_nxt = IDLE;
            end
            WAIT_HIGH: if (TE) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr      <= '0;
            owner    <= '0;
            load     <= 1'b0;
            ack      <= '0;
            dout     <= 8'h00;
            err      <= 1'b0;
            tx_count <= 16'h0000;
            to_cnt   <= '0;
        end else begin
            load <= 1'b0;
            ack  <= '0;
            if (state == IDLE && state_nxt == LOAD) begin
                load  <= 1'b1;
                ack   <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                owner <= winner;
                dout  <= din[8*winner +: 8];
            end
            if (state == LOAD) begin
                ptr      <= owner + OW'(1);
                tx_count <= tx_count + 16'd1;
            end
            // WAIT_LOW is only entered from LOAD, so clearing here restarts every wait.
            if (state == LOAD)
                to_cnt <= '0;
            else if (state == WAIT_LOW && TE && !to_expire)
                to_cnt <= to_cnt + TW'(1);
            if (to_expire)    err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of requesters (fixed at 4 for this revision).
REQ-002 The block SHALL have parameter TO_CYCLES, default 16, meaning the maximum clk cycles to wait for TE to fall after a load.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 4, per-requester transmit request, held until acked.
REQ-006 The block SHALL have port din, input, 32, requester i byte on din[8i+7:8i], stable while req[i]=1.
REQ-007 The block SHALL have port ack, output, 4, one-cycle pulse: byte of requester i taken.
REQ-008 The block SHALL have port TE, input, 1, transmitter data-register-empty flag.
REQ-009 The block SHALL have port load, output, 1, one-cycle parallel-load strobe to the transmitter.
REQ-010 The block SHALL have port dout, output, 8, byte presented to the transmitter, valid while load=1.
REQ-011 The block SHALL have port owner, output, 2, index of the current or last granted requester.
REQ-012 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 The block SHALL have port err, output, 1, sticky timeout flag.
REQ-014 The block SHALL have port err_clr, input, 1, synchronous clear of err.
REQ-015 The block SHALL have port tx_count, output, 16, count of bytes loaded, wrapping from 16'hFFFF to 0.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WAIT_LOW and WAIT_HIGH.
REQ-017 In IDLE with TE=1 and req!=0, the FSM SHALL pick a winner round-robin starting at pointer ptr, register owner and dout=din[winner], and move to LOAD.
REQ-018 In IDLE with TE=0, the FSM SHALL stay in IDLE regardless of req (transmitter busy).
REQ-019 In LOAD, load=1 and ack[owner]=1 SHALL be asserted for exactly this one cycle, ptr SHALL become owner+1 mod 4, tx_count SHALL increment, and the next state SHALL be WAIT_LOW.
REQ-020 load, ack, dout and owner SHALL be registered outputs, with no combinational path from req or TE.
REQ-021 In WAIT_LOW, TE=0 SHALL move the FSM to WAIT_HIGH.
REQ-022 In WAIT_LOW, if TE stays 1 for TO_CYCLES cycles counted from entry, the block SHALL set err=1 and return to IDLE.
REQ-023 In WAIT_HIGH, TE=1 SHALL move the FSM to IDLE; there SHALL be no timeout in WAIT_HIGH.
REQ-024 The timeout counter SHALL clear on every entry to WAIT_LOW.
REQ-025 Latency: a request seen in IDLE at edge n SHALL produce load at cycle n+1.
REQ-026 The minimum spacing between two loads SHALL be 4 cycles: LOAD, WAIT_LOW, WAIT_HIGH, IDLE.
REQ-027 A requester whose req is still high after its ack SHALL be treated as a new byte.
REQ-028 Requests dropped before grant SHALL be ignored without error.
REQ-029 If err_clr and a timeout occur in the same cycle, err SHALL be 1 (set wins).
REQ-030 The block SHALL issue ack only in LOAD and SHALL assert at most one ack bit per cycle.

Reset
REQ-031 While resetn=0, the block SHALL hold: state=IDLE, ptr=0, owner=0, load=0, ack=0, dout=8'h00, err=0, tx_count=0, timeout counter=0.
REQ-032 A resetn assertion mid-transfer SHALL abort immediately with no further load or ack pulse; after release the block SHALL resume from IDLE with ptr=0.

Verification
REQ-033 Bench SHALL cover: req=4'b0001, din[7:0]=8'hA5, TE=1 -> load and ack[0] one cycle later, dout=8'hA5, tx_count=1.
REQ-034 Bench SHALL cover: req=4'b1111 held, with TE emulating the transmitter -> grant order 0,1,2,3,0 and exactly one ack per load.
REQ-035 Bench SHALL cover: TE held 1 after load -> err=1 after 16 cycles in WAIT_LOW, FSM in IDLE; err_clr -> err=0.
REQ-036 Bench SHALL cover: TE=0 in IDLE with req=4'b0100 -> no load until TE=1, then load with owner=2.
REQ-037 Bench SHALL cover: resetn pulsed low during WAIT_HIGH -> all outputs at reset values, no load or ack, next grant starts from requester 0.
REQ-038 Bench SHALL cover: 65536 loads -> tx_count wraps to 0.
